// File: rtl/cnn_mem_chk.sv
// cnn_mem_chk -- banked layer memory with a streaming compare checker.
//
// NBANK banks of DEPTH x DW words, selected 1..NBANK by csel. A host port
// writes (cwr) and reads (crd, one-cycle latency) the banks. A checker
// pass (chk_start) walks one bank from address 0, comparing each stored
// word against a streamed expected word (exp_valid/exp_ready handshake),
// counting mismatches and capturing the first mismatching address.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   csel              bank select for host writes and reads (1..NBANK)
//   cwr/caddr_wr/cdata_wr   host write strobe, address, data
//   crd/caddr_rd/cdata_rd   host read strobe, address, registered data
//   chk_start/chk_bank/chk_len   start a compare pass of chk_len words
//   exp_valid/exp_data/exp_ready expected-word stream
//   chk_busy, chk_done       pass active, one-cycle completion pulse
//   err_cnt, first_err_addr  mismatch count and first mismatch address
//   wr_seen, bad_sel         sticky per-bank write flags, illegal-select flag
//
// Build option: define CNN_CHK_TOL_EN to accept words whose modular
// difference from the expected word is within TOL LSBs.
//
// Checker FSM:
//   state | meaning
//   IDLE  | waiting for chk_start
//   RUN   | accepting expected words, comparing against the latched bank
//   DONE  | one cycle, chk_done pulse, results stable

module cnn_mem_chk #(
  parameter int DW    = 20,
  parameter int AW    = 12,
  parameter int NBANK = 5,
  parameter int DEPTH = 4096,
  parameter int TOL   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        csel,
  input  logic              cwr,
  input  logic [AW-1:0]     caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  input  logic              crd,
  input  logic [AW-1:0]     caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic              chk_start,
  input  logic [2:0]        chk_bank,
  input  logic [AW:0]       chk_len,
  input  logic              exp_valid,
  input  logic [DW-1:0]     exp_data,
  output logic              exp_ready,
  output logic              chk_busy,
  output logic              chk_done,
  output logic [AW:0]       err_cnt,
  output logic [AW-1:0]     first_err_addr,
  output logic [NBANK-1:0]  wr_seen,
  output logic              bad_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [NBANK][DEPTH];

  logic          sel_ok;
  logic [2:0]    sel_idx;
  logic          wr_ok;
  logic          rd_ok;

  logic [2:0]    bank_q;
  logic [2:0]    bank_idx;
  logic          bank_ok;
  logic [AW:0]   ptr;
  logic [AW:0]   rem;
  logic          first_seen;
  logic          accept;
  logic          last_word;
  logic [DW-1:0] chk_word;
  logic          word_match;

  // Host port decode
  assign sel_ok  = (csel != 3'd0) && (32'(csel) <= NBANK);
  assign sel_idx = csel - 3'd1;
  assign wr_ok   = cwr && sel_ok && (32'(caddr_wr) < DEPTH);
  assign rd_ok   = sel_ok && (32'(caddr_rd) < DEPTH);

  // Bank storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[sel_idx][caddr_wr] <= cdata_wr;
    end
  end

  // Checker datapath: the stored word is read combinationally, so a host
  // write landing in the same cycle is not yet visible (old data compared).
  assign bank_ok   = (bank_q != 3'd0) && (32'(bank_q) <= NBANK);
  assign bank_idx  = bank_q - 3'd1;
  assign accept    = (state == RUN) && exp_valid;
  assign last_word = (rem == (AW+1)'(1));

  always_comb begin
    chk_word = '0;
    if (bank_ok && (32'(ptr) < DEPTH)) begin
      chk_word = mem[bank_idx][ptr[AW-1:0]];
    end
  end

`ifdef CNN_CHK_TOL_EN
  logic [DW-1:0] diff_pos;
  logic [DW-1:0] diff_neg;
  assign diff_pos   = chk_word - exp_data;
  assign diff_neg   = exp_data - chk_word;
  assign word_match = (diff_pos <= DW'(TOL)) || (diff_neg <= DW'(TOL));
`else
  assign word_match = (chk_word == exp_data);
`endif

  // FSM next state and outputs
  always_comb begin
    state_nxt = state;
    exp_ready = 1'b0;
    chk_busy  = 1'b0;
    chk_done  = 1'b0;
    case (state)
      IDLE: begin
        if (chk_start) begin
          state_nxt = (chk_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        exp_ready = 1'b1;
        chk_busy  = 1'b1;
        if (accept && last_word) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        chk_busy  = 1'b1;
        chk_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Checker registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q         <= '0;
      ptr            <= '0;
      rem            <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_seen     <= 1'b0;
    end else begin
      if ((state == IDLE) && chk_start) begin
        bank_q         <= chk_bank;
        ptr            <= '0;
        rem            <= chk_len;
        err_cnt        <= '0;
        first_err_addr <= '0;
        first_seen     <= 1'b0;
      end else if (accept) begin
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
        if (!word_match) begin
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
          end
          if (!first_seen) begin
            first_err_addr <= ptr[AW-1:0];
            first_seen     <= 1'b1;
          end
        end
      end
    end
  end

  // Host read port and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cdata_rd <= '0;
      wr_seen  <= '0;
      bad_sel  <= 1'b0;
    end else begin
      if (crd) begin
        cdata_rd <= rd_ok ? mem[sel_idx][caddr_rd] : '0;
      end
      if (wr_ok) begin
        wr_seen[sel_idx] <= 1'b1;
      end
      if (cwr && !sel_ok) begin
        bad_sel <= 1'b1;
      end
    end
  end

endmodule
